// File: rtl/core_seq.sv
// core_seq -- multi-cycle fetch/execute sequencer for the RISC-V core.
//
// Owns the program counter, fetches one instruction at a time from
// instruction memory over a req/ack handshake, then spends exactly one
// EXEC cycle in which the decoder's register-file write enable is allowed
// through. Adds run/step/stop debug control, a programmable halt address,
// a fetch timeout and a saturating retired-instruction counter.
//
// Ports:
//   clk, rst     clock (posedge) and asynchronous active-high reset
//   run          level: free-run while high
//   step         pulse: execute exactly one instruction from IDLE
//   stop         pulse: return to IDLE after the current instruction
//   clr_halt     pulse: leave HALT, clear err, pc back to 0
//   last_pc      halt after executing the instruction at this address
//   imem_req     fetch request, high for the whole FETCH state
//   imem_addr    fetch address (always equal to pc)
//   imem_ack     fetch complete, imem_rdata valid this cycle
//   imem_rdata   fetched instruction word
//   instr        latched instruction for the decoder
//   pc           current instruction address
//   rf_we_dec    write enable from the control decoder
//   rf_we        gated write enable (only live in EXEC)
//   busy         state is FETCH or EXEC
//   halted       state is HALT
//   err          sticky fetch-timeout flag
//   retired      saturating count of executed instructions

module core_seq #(
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic              stop,
    input  logic              clr_halt,
    input  logic [ADDR_W-1:0] last_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc,
    input  logic              rf_we_dec,
    output logic              rf_we,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    // Wide enough to hold TIMEOUT-1; at least one bit so a disabled
    // timeout still yields a legal (unused) counter.
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [1:0]      state;
    logic            step_mode;
    logic            stop_pend;
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    // The current FETCH cycle is the TIMEOUT-th one without an ack; an ack
    // arriving in that same cycle still wins.
    assign to_hit = (TIMEOUT != 0) && (to_cnt == TO_W'(TIMEOUT - 1));

    // Handshake and status outputs decode straight from the state register,
    // so an asynchronous reset drops imem_req without waiting for a clock.
    always_comb begin
        imem_req  = (state == S_FETCH);
        imem_addr = pc;
        rf_we     = (state == S_EXEC) && rf_we_dec;
        busy      = (state == S_FETCH) || (state == S_EXEC);
        halted    = (state == S_HALT);
    end

    // Sequencer: IDLE waits for run/step, FETCH holds the request until the
    // memory acks (or the timeout fires), EXEC retires the instruction and
    // advances pc, HALT parks until clr_halt. A stop seen during FETCH is
    // remembered so the in-flight handshake always completes first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            instr     <= '0;
            err       <= 1'b0;
            retired   <= '0;
            step_mode <= 1'b0;
            stop_pend <= 1'b0;
            to_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state     <= S_FETCH;
                        step_mode <= 1'b0;
                        to_cnt    <= '0;
                    end else if (step) begin
                        state     <= S_FETCH;
                        step_mode <= 1'b1;
                        to_cnt    <= '0;
                    end
                end

                S_FETCH: begin
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (imem_ack) begin
                        instr  <= imem_rdata;
                        state  <= S_EXEC;
                        to_cnt <= '0;
                    end else if (to_hit) begin
                        state     <= S_HALT;
                        err       <= 1'b1;
                        to_cnt    <= '0;
                        stop_pend <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                S_EXEC: begin
                    stop_pend <= 1'b0;
                    if (retired != '1) begin
                        retired <= retired + 1'b1;
                    end
                    if (pc == last_pc) begin
                        state <= S_HALT;
                    end else begin
                        pc <= pc + 1'b1;
                        if (step_mode || stop_pend || stop || !run) begin
                            state <= S_IDLE;
                        end else begin
                            state  <= S_FETCH;
                            to_cnt <= '0;
                        end
                    end
                end

                S_HALT: begin
                    // retired is deliberately kept across a halt.
                    if (clr_halt) begin
                        state     <= S_IDLE;
                        pc        <= '0;
                        err       <= 1'b0;
                        step_mode <= 1'b0;
                        stop_pend <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq -- self-checking bench for core_seq.
//
// An environment process plays instruction memory (configurable ack delay,
// addresses from dead_from upward never ack) and drives a random rf_we_dec.
// Scenario tasks push the pc sequence they expect into exp_q; the
// environment checks each fetch address against the queue head and pops it
// when the execute cycle comes round, comparing pc and the latched word.

module tb_core_seq;

    localparam int ADDR_W     = 32;
    localparam int CNT_W      = 32;
    localparam int TB_TIMEOUT = 4;

    logic              clk;
    logic              rst;
    logic              run;
    logic              step;
    logic              stop;
    logic              clr_halt;
    logic [ADDR_W-1:0] last_pc;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
    logic              rf_we_dec;
    logic              rf_we;
    logic              busy;
    logic              halted;
    logic              err;
    logic [CNT_W-1:0]  retired;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    int          ack_delay = 0;
    logic [31:0] dead_from = 32'hFFFF_FFFF;

    core_seq #(
        .ADDR_W  (ADDR_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step       (step),
        .stop       (stop),
        .clr_halt   (clr_halt),
        .last_pc    (last_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .pc         (pc),
        .rf_we_dec  (rf_we_dec),
        .rf_we      (rf_we),
        .busy       (busy),
        .halted     (halted),
        .err        (err),
        .retired    (retired)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction word the memory returns for a given address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return ({a[15:0], 16'h0000} ^ 32'h0000_0513) + (a * 32'h0000_9E37);
    endfunction

    // Memory / decoder environment. Each negedge it first checks the cycle
    // just completed against what it told the DUT on the previous negedge,
    // then decides ack, read data and rf_we_dec for the next posedge.
    initial begin : env
        logic        exec_exp;
        logic        hold;
        logic [31:0] hold_addr;
        logic [31:0] last_instr;
        logic [31:0] a;
        int          wait_cnt;
        exec_exp   = 1'b0;
        hold       = 1'b0;
        hold_addr  = '0;
        last_instr = '0;
        wait_cnt   = 0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        rf_we_dec  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exec_exp   = 1'b0;
                hold       = 1'b0;
                wait_cnt   = 0;
                last_instr = '0;
                imem_ack   = 1'b0;
            end else begin
                checks++;
                if (rf_we !== (exec_exp & rf_we_dec)) begin
                    errors++;
                    $display("[TB] FAIL rf_we_gate: got %0b expected %0b", rf_we, exec_exp & rf_we_dec);
                end
                if (exec_exp) begin
                    checks++;
                    if (busy !== 1'b1 || imem_req !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL exec_state: got busy=%0b req=%0b expected busy=1 req=0", busy, imem_req);
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL exec_unexpected: got pc=%0h expected no execute", pc);
                    end else begin
                        a = exp_q.pop_front();
                        checks++;
                        if (pc !== a || instr !== instr_of(a)) begin
                            errors++;
                            $display("[TB] FAIL exec_pc_instr: got pc=%0h instr=%0h expected pc=%0h instr=%0h",
                                     pc, instr, a, instr_of(a));
                        end
                    end
                end
                if (hold) begin
                    checks++;
                    if (wait_cnt == TB_TIMEOUT) begin
                        if (halted !== 1'b1 || err !== 1'b1 || imem_req !== 1'b0 || pc !== hold_addr) begin
                            errors++;
                            $display("[TB] FAIL timeout_halt: got halted=%0b err=%0b req=%0b pc=%0h expected 1 1 0 %0h",
                                     halted, err, imem_req, pc, hold_addr);
                        end
                    end else if (imem_req !== 1'b1 || imem_addr !== hold_addr || instr !== last_instr) begin
                        errors++;
                        $display("[TB] FAIL fetch_hold: got req=%0b addr=%0h instr=%0h expected 1 %0h %0h",
                                 imem_req, imem_addr, instr, hold_addr, last_instr);
                    end
                end

                exec_exp = 1'b0;
                hold     = 1'b0;
                if (imem_req === 1'b1) begin
                    if (wait_cnt == 0) begin
                        checks++;
                        if (exp_q.size() == 0 || imem_addr !== exp_q[0]) begin
                            errors++;
                            $display("[TB] FAIL fetch_addr: got %0h expected %0h (queue %0d)",
                                     imem_addr, (exp_q.size() != 0) ? exp_q[0] : 32'hx, exp_q.size());
                        end
                    end
                    if (imem_addr < dead_from && wait_cnt == ack_delay) begin
                        imem_ack   = 1'b1;
                        imem_rdata = instr_of(imem_addr);
                        last_instr = imem_rdata;
                        exec_exp   = 1'b1;
                        wait_cnt   = 0;
                    end else begin
                        imem_ack   = 1'b0;
                        imem_rdata = $urandom;
                        hold       = 1'b1;
                        hold_addr  = imem_addr;
                        wait_cnt++;
                    end
                end else begin
                    // Stray acks outside FETCH must be ignored by the DUT.
                    imem_ack   = 1'($urandom_range(0, 1));
                    imem_rdata = $urandom;
                    wait_cnt   = 0;
                end
                rf_we_dec = 1'($urandom_range(0, 1));
            end
        end
    end

    // Assert reset across two clock edges and return the controls to idle.
    task automatic apply_reset();
        rst       = 1'b1;
        run       = 1'b0;
        step      = 1'b0;
        stop      = 1'b0;
        clr_halt  = 1'b0;
        ack_delay = 0;
        dead_from = 32'hFFFF_FFFF;
        last_pc   = 32'hFFFF_FFFF;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (imem_req !== 1'b0 || pc !== '0 || instr !== '0 || rf_we !== 1'b0 || busy !== 1'b0 ||
            halted !== 1'b0 || err !== 1'b0 || retired !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values: got req=%0b pc=%0h instr=%0h we=%0b busy=%0b halt=%0b err=%0b ret=%0d expected all zero",
                     imem_req, pc, instr, rf_we, busy, halted, err, retired);
        end
        // stop in IDLE changes nothing
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_stop: got busy=%0b halted=%0b expected 0 0", busy, halted);
        end
    endtask

    // Same-cycle ack: four instructions at two cycles each, halt at pc 3.
    task automatic test_run_to_last_pc();
        int n;
        apply_reset();
        last_pc = 32'd3;
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        run = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (halted !== 1'b1 && n < 100);
        checks++;
        if (n != 9) begin
            errors++;
            $display("[TB] FAIL run_cycles: got %0d expected 9", n);
        end
        checks++;
        if (pc !== 32'd3 || retired !== 32'd4 || busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL run_halt: got pc=%0h ret=%0d busy=%0b left=%0d expected 3 4 0 0",
                     pc, retired, busy, exp_q.size());
        end
        // run/step are ignored while halted
        step = 1'b1;
        repeat (2) @(negedge clk);
        step = 1'b0;
        checks++;
        if (halted !== 1'b1 || pc !== 32'd3) begin
            errors++;
            $display("[TB] FAIL halt_sticky: got halted=%0b pc=%0h expected 1 3", halted, pc);
        end
        run = 1'b0;
    endtask

    // Ack three cycles late: four request cycles and five cycles per instruction.
    task automatic test_ack_delay();
        int n;
        int req_cycles;
        apply_reset();
        ack_delay = 3;
        last_pc   = 32'd1;
        exp_q.push_back(0);
        exp_q.push_back(1);
        run = 1'b1;
        n = 0;
        req_cycles = 0;
        do begin
            @(negedge clk);
            n++;
            if (imem_req === 1'b1) req_cycles++;
        end while (halted !== 1'b1 && n < 100);
        checks++;
        if (n != 11 || req_cycles != 8) begin
            errors++;
            $display("[TB] FAIL ack_delay_timing: got cycles=%0d req=%0d expected 11 8", n, req_cycles);
        end
        checks++;
        if (retired !== 32'd2 || err !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL ack_delay_result: got ret=%0d err=%0b left=%0d expected 2 0 0",
                     retired, err, exp_q.size());
        end
        run = 1'b0;
    endtask

    // Two single-step pulses with run low: back to IDLE after each.
    task automatic test_step();
        int n;
        apply_reset();
        ack_delay = 1;
        exp_q.push_back(0);
        exp_q.push_back(1);
        for (int i = 0; i < 2; i++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL step_start: got busy=%0b expected 1", busy);
            end
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (busy === 1'b1 && n < 20);
            checks++;
            if (busy !== 1'b0 || halted !== 1'b0 || pc !== 32'(i + 1)) begin
                errors++;
                $display("[TB] FAIL step_done: got busy=%0b halted=%0b pc=%0h expected 0 0 %0h",
                         busy, halted, pc, i + 1);
            end
        end
        checks++;
        if (retired !== 32'd2 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL step_retired: got %0d left=%0d expected 2 0", retired, exp_q.size());
        end
    endtask

    // stop during the fetch of pc 5 lets that instruction finish.
    task automatic test_stop();
        int n;
        apply_reset();
        ack_delay = 2;
        for (int i = 0; i < 6; i++) exp_q.push_back(i);
        run = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_req === 1'b1 && imem_addr === 32'd5) && n < 100);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd5) begin
            errors++;
            $display("[TB] FAIL stop_reach_pc5: got req=%0b addr=%0h expected 1 5", imem_req, imem_addr);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        run = 1'b0;
        checks++;
        if (busy !== 1'b0 || pc !== 32'd6 || retired !== 32'd6 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL stop_idle: got busy=%0b pc=%0h ret=%0d left=%0d expected 0 6 6 0",
                     busy, pc, retired, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0 || pc !== 32'd6) begin
            errors++;
            $display("[TB] FAIL stop_stays_idle: got busy=%0b halted=%0b pc=%0h expected 0 0 6", busy, halted, pc);
        end
    endtask

    // Memory stops answering at pc 2: timeout halts with pc and count kept.
    task automatic test_timeout();
        int n;
        int dead_req;
        apply_reset();
        dead_from = 32'd2;
        for (int i = 0; i < 3; i++) exp_q.push_back(i);
        run = 1'b1;
        n = 0;
        dead_req = 0;
        do begin
            @(negedge clk);
            n++;
            if (imem_req === 1'b1 && imem_addr === 32'd2) dead_req++;
        end while (halted !== 1'b1 && n < 100);
        checks++;
        if (n != 9 || dead_req != TB_TIMEOUT) begin
            errors++;
            $display("[TB] FAIL timeout_timing: got cycles=%0d fetch=%0d expected 9 %0d", n, dead_req, TB_TIMEOUT);
        end
        checks++;
        if (err !== 1'b1 || pc !== 32'd2 || retired !== 32'd2 || exp_q.size() != 1) begin
            errors++;
            $display("[TB] FAIL timeout_state: got err=%0b pc=%0h ret=%0d left=%0d expected 1 2 2 1",
                     err, pc, retired, exp_q.size());
        end
        exp_q.delete();
        run = 1'b0;
        clr_halt = 1'b1;
        @(negedge clk);
        clr_halt = 1'b0;
        checks++;
        if (halted !== 1'b0 || err !== 1'b0 || pc !== '0 || busy !== 1'b0 || retired !== 32'd2) begin
            errors++;
            $display("[TB] FAIL clr_halt: got halted=%0b err=%0b pc=%0h busy=%0b ret=%0d expected 0 0 0 0 2",
                     halted, err, pc, busy, retired);
        end
    endtask

    // Reset mid-fetch at pc 7 clears everything without a clock edge.
    task automatic test_async_reset();
        int n;
        apply_reset();
        dead_from = 32'd7;
        for (int i = 0; i < 8; i++) exp_q.push_back(i);
        run = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_req === 1'b1 && imem_addr === 32'd7) && n < 100);
        checks++;
        if (imem_req !== 1'b1 || pc !== 32'd7 || retired !== 32'd7) begin
            errors++;
            $display("[TB] FAIL pre_reset: got req=%0b pc=%0h ret=%0d expected 1 7 7", imem_req, pc, retired);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc !== '0 || instr !== '0 || rf_we !== 1'b0 || busy !== 1'b0 ||
            halted !== 1'b0 || err !== 1'b0 || retired !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got req=%0b pc=%0h instr=%0h we=%0b busy=%0b halt=%0b err=%0b ret=%0d expected all zero",
                     imem_req, pc, instr, rf_we, busy, halted, err, retired);
        end
        run = 1'b0;
        exp_q.delete();
        dead_from = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_pc = 32'd1;
        exp_q.push_back(0);
        exp_q.push_back(1);
        run = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (halted !== 1'b1 && n < 100);
        checks++;
        if (halted !== 1'b1 || pc !== 32'd1 || retired !== 32'd2 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL restart: got halted=%0b pc=%0h ret=%0d left=%0d expected 1 1 2 0",
                     halted, pc, retired, exp_q.size());
        end
        run = 1'b0;
    endtask

    // Scenario sequence and final summary.
    initial begin
        rst       = 1'b1;
        run       = 1'b0;
        step      = 1'b0;
        stop      = 1'b0;
        clr_halt  = 1'b0;
        last_pc   = 32'hFFFF_FFFF;
        test_reset();
        test_run_to_last_pc();
        test_ack_delay();
        test_step();
        test_stop();
        test_timeout();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case a scenario never terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
